// File: rtl/axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the master_file initiator and axil_slave_regs.
// The wstrb signal exists only when AXIL_SLAVE_WSTRB_EN is defined.
interface axil_slave_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
`ifdef AXIL_SLAVE_WSTRB_EN
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
`endif
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid,
        output wdata,
`ifdef AXIL_SLAVE_WSTRB_EN
        output wstrb,
`endif
        output wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        input  wdata,
`ifdef AXIL_SLAVE_WSTRB_EN
        input  wstrb,
`endif
        input  wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_regs.sv
// AXI4-Lite responder with a flat memory-mapped register file.
// Independent write (W_IDLE/W_HAVE_A/W_HAVE_D/W_RESP) and read (R_IDLE/R_DATA)
// state machines; all registers are also exported on regs_out.
// Optional byte-lane strobes: define AXIL_SLAVE_WSTRB_EN to add bus.wstrb.
module axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    localparam int ADDR_LSB = (C_S_AXI_DATA_WIDTH == 64) ? 3 : 2,
    localparam int NUM_REGS = 2 ** (C_S_AXI_ADDR_WIDTH - ADDR_LSB)
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    axil_slave_regs_if.slave                       bus,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_out
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W  = AW - ADDR_LSB;
    localparam int STRB_W = DW / 8;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // Byte-lane merge: lanes with a set strobe take the new byte.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0]     old_word,
        input logic [DW-1:0]     new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

    logic [DW-1:0]     regs [NUM_REGS];

    wstate_t           w_state, w_state_nxt;
    idx_t              w_addr_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [STRB_W-1:0] in_strb;

    logic              aw_rdy, w_rdy, b_vld;
    logic              aw_latch, w_latch;
    logic              wr_en;
    idx_t              wr_idx;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;

    rstate_t           r_state, r_state_nxt;
    logic              ar_rdy, r_vld, rd_load;
    logic [DW-1:0]     rdata_q;

    idx_t              aw_idx, ar_idx;

    assign aw_idx = bus.awaddr[AW-1:ADDR_LSB];
    assign ar_idx = bus.araddr[AW-1:ADDR_LSB];

`ifdef AXIL_SLAVE_WSTRB_EN
    assign in_strb = bus.wstrb;
`else
    // Without strobes every write is a full-word write.
    assign in_strb = '1;
`endif

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.awprot, bus.arprot,
                           bus.awaddr[ADDR_LSB-1:0], bus.araddr[ADDR_LSB-1:0]};

    // Write FSM next state, ready decodes and register commit selection.
    always_comb begin
        w_state_nxt = w_state;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        aw_latch    = 1'b0;
        w_latch     = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = w_addr_q;
        wr_data     = w_data_q;
        wr_strb     = w_strb_q;
        case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (bus.awvalid && bus.wvalid) begin
                    wr_en       = 1'b1;
                    wr_idx      = aw_idx;
                    wr_data     = bus.wdata;
                    wr_strb     = in_strb;
                    w_state_nxt = W_RESP;
                end else if (bus.awvalid) begin
                    aw_latch    = 1'b1;
                    w_state_nxt = W_HAVE_A;
                end else if (bus.wvalid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_rdy = 1'b1;
                if (bus.wvalid) begin
                    wr_en       = 1'b1;
                    wr_idx      = w_addr_q;
                    wr_data     = bus.wdata;
                    wr_strb     = in_strb;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_D: begin
                aw_rdy = 1'b1;
                if (bus.awvalid) begin
                    wr_en       = 1'b1;
                    wr_idx      = aw_idx;
                    wr_data     = w_data_q;
                    wr_strb     = w_strb_q;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (bus.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state and the half-transaction holding registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state  <= W_IDLE;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_latch) w_addr_q <= aw_idx;
            if (w_latch) begin
                w_data_q <= bus.wdata;
                w_strb_q <= in_strb;
            end
        end
    end

    // Register file: cleared on reset, byte-merged on a completed write.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= merge_bytes(regs[wr_idx], wr_data, wr_strb);
        end
    end

    // Read FSM next state; rvalid is held until the R handshake.
    always_comb begin
        r_state_nxt = r_state;
        ar_rdy      = 1'b0;
        r_vld       = 1'b0;
        rd_load     = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (bus.arvalid) begin
                    rd_load     = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (bus.rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and read-data capture; a same-edge write is not yet visible.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (rd_load) rdata_q <= regs[ar_idx];
        end
    end

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = b_vld;
    assign bus.bresp   = 2'b00;
    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = 2'b00;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
        assign regs_out[i*DW +: DW] = regs[i];
    end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Bench for axil_slave_regs: table of single transactions plus hand-written
// multi-cycle sequences; read data is checked through an expected-value queue.
module tb_axil_slave_regs;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 4;
    localparam int SW   = DW / 8;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
    } vec_t;

    logic               aclk = 1'b0;
    logic               areset;
    logic [DW*NREG-1:0] regs_out;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [DW-1:0]      exp_q[$];
    logic [DW-1:0]      model[NREG];
    vec_t               vecs[10];

    axil_slave_regs_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) bus ();

    axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .bus     (bus),
        .regs_out(regs_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
`ifdef AXIL_SLAVE_WSTRB_EN
        bus.wstrb   = '1;
`endif
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
    endtask

    function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                                 input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Pop the oldest expected read and compare against the DUT's R channel.
    task automatic sb_check_read(input string name);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.rdata, e);
            check({name, "_rresp"}, bus.rresp, 2'b00);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb, input string name);
        bit aw_done, w_done;
        int n;
        logic [SW-1:0] eff;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
`ifdef AXIL_SLAVE_WSTRB_EN
        bus.wstrb   = strb;
        eff         = strb;
`else
        eff         = strb | '1;
`endif
        aw_done = 0;
        w_done  = 0;
        n       = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            @(negedge aclk);
            n++;
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
        end
        check({name, "_handshake"}, {aw_done, w_done}, 2'b11);
        check({name, "_bvalid"}, bus.bvalid, 1'b1);
        check({name, "_bresp"}, bus.bresp, 2'b00);
        @(negedge aclk);
        check({name, "_bvalid_drop"}, bus.bvalid, 1'b0);
        bus.bready = 1'b0;
        model[addr[AW-1:2]] = strb_merge(model[addr[AW-1:2]], data, eff);
        check({name, "_regs_out"}, regs_out[addr[AW-1:2]*DW +: DW], model[addr[AW-1:2]]);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        int n;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_arready_wait"}, (n < 20), 1'b1);
        exp_q.push_back(exp);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        check({name, "_rvalid_lat"}, bus.rvalid, 1'b1);
        n = 0;
        while (!bus.rvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        sb_check_read(name);
        @(negedge aclk);
        bus.rready = 1'b0;
        check({name, "_rvalid_drop"}, bus.rvalid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'h0, 32'h0000_0000};
        vecs[1] = '{1'b0, 4'h4, 32'h0000_0000};
        vecs[2] = '{1'b0, 4'h8, 32'h0000_0000};
        vecs[3] = '{1'b0, 4'hC, 32'h0000_0000};
        vecs[4] = '{1'b1, 4'h8, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 4'h8, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 4'h1, 32'hA5A5_0001};
        vecs[7] = '{1'b0, 4'h3, 32'hA5A5_0001};
        vecs[8] = '{1'b1, 4'hC, 32'h0000_FFFF};
        vecs[9] = '{1'b0, 4'hE, 32'h0000_FFFF};
        for (int i = 0; i < NREG; i++) model[i] = '0;

        idle_inputs();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_rdata",   bus.rdata,   32'h0);
        check("rst_awready", bus.awready, 1'b1);
        check("rst_wready",  bus.wready,  1'b1);
        check("rst_arready", bus.arready, 1'b1);
        check("rst_regs",    regs_out[63:0], 64'h0);
        check("rst_regs_hi", regs_out[127:64], 64'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, '1, $sformatf("vec%0d_wr", i));
            else axi_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_rd", i));
        end
        check("deadbeef_bits", regs_out[95:64], 32'hDEAD_BEEF);

        // W three cycles ahead of AW, response held off by bready low.
        bus.wdata  = 32'h1234_5678;
        bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        check("wfirst_wready", bus.wready, 1'b1);
        @(negedge aclk);
        bus.wvalid = 1'b0;
        check("wfirst_wready_low", bus.wready, 1'b0);
        check("wfirst_awready", bus.awready, 1'b1);
        check("wfirst_no_bvalid", bus.bvalid, 1'b0);
        repeat (2) @(negedge aclk);
        bus.awaddr  = 4'h4;
        bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wfirst_bvalid_hold%0d", i), bus.bvalid, 1'b1);
            check($sformatf("wfirst_awready_low%0d", i), bus.awready, 1'b0);
            if (i < 3) @(negedge aclk);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check("wfirst_bvalid_drop", bus.bvalid, 1'b0);
        check("wfirst_reg1", regs_out[63:32], 32'h1234_5678);
        model[1] = 32'h1234_5678;

        // Stalled read of 0xC while 0x0 is written underneath it.
        bus.araddr  = 4'hC;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        exp_q.push_back(32'h0000_FFFF);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        check("stall_rvalid", bus.rvalid, 1'b1);
        sb_check_read("stall_rdata_first");
        bus.awaddr  = 4'h0;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hCAFE_F00D;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_rvalid_hold%0d", i), bus.rvalid, 1'b1);
            check($sformatf("stall_rdata_hold%0d", i), bus.rdata, 32'h0000_FFFF);
            check($sformatf("stall_arready%0d", i), bus.arready, 1'b0);
            @(negedge aclk);
            if (i == 0) begin
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
            end
        end
        bus.bready = 1'b0;
        check("stall_reg0", regs_out[31:0], 32'hCAFE_F00D);
        model[0] = 32'hCAFE_F00D;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        check("stall_rvalid_drop", bus.rvalid, 1'b0);
        check("stall_arready_back", bus.arready, 1'b1);

        // Read and write of the same word on the same edge.
        axi_write(4'h4, 32'h1111_1111, '1, "same_pre");
        bus.awaddr  = 4'h4;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h2222_2222;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        bus.araddr  = 4'h4;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        exp_q.push_back(32'h1111_1111);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check("same_bvalid", bus.bvalid, 1'b1);
        check("same_rvalid", bus.rvalid, 1'b1);
        sb_check_read("same_old_value");
        @(negedge aclk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        check("same_bvalid_drop", bus.bvalid, 1'b0);
        model[1] = 32'h2222_2222;
        axi_read(4'h4, 32'h2222_2222, "same_new_value");

        // Reset with a half write (address only) and an unaccepted read pending.
        bus.awaddr  = 4'h8;
        bus.awvalid = 1'b1;
        bus.araddr  = 4'h8;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        check("pend_awready", bus.awready, 1'b0);
        check("pend_wready", bus.wready, 1'b1);
        check("pend_rvalid", bus.rvalid, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        check("rst2_bvalid", bus.bvalid, 1'b0);
        check("rst2_rvalid", bus.rvalid, 1'b0);
        check("rst2_rdata", bus.rdata, 32'h0);
        check("rst2_awready", bus.awready, 1'b1);
        check("rst2_regs", regs_out, {(DW*NREG){1'b0}});
        repeat (2) @(negedge aclk);
        check("rst2_no_bvalid", bus.bvalid, 1'b0);
        for (int i = 0; i < NREG; i++) axi_read(AW'(i * 4), 32'h0, $sformatf("rst2_rd%0d", i));

`ifdef AXIL_SLAVE_WSTRB_EN
        axi_write(4'h0, 32'hAABB_CCDD, 4'b0101, "strb_0101");
        check("strb_0101_value", regs_out[31:0], 32'h00BB_00DD);
        axi_read(4'h0, 32'h00BB_00DD, "strb_0101_rd");
        axi_write(4'h0, 32'hFFFF_FFFF, 4'b0000, "strb_none");
        axi_read(4'h0, 32'h00BB_00DD, "strb_none_rd");
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
